// File: rtl/fib_timer_buffer_pkg.sv
// fib_timer_buffer_pkg: shared buffer sizing and top-level control FSM state encodings
package fib_timer_buffer_pkg;
  localparam int FTB_DATA_W = 16;
  localparam int FTB_DEPTH  = 8;
  localparam int FTB_PTR_W  = $clog2(FTB_DEPTH);
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_FIB       = 3'd2;
  localparam logic [2:0] S_TIMER     = 3'd3;
  localparam logic [2:0] S_COMM      = 3'd4;
  localparam logic [2:0] S_WAIT      = 3'd5;
  localparam logic [2:0] S_BUF_EMPTY = 3'd6;
endpackage

// File: rtl/fib_timer_buffer_mem.sv
// fib_timer_buffer_mem: DEPTH x DATA_W register array, synchronous write, combinational read
module fib_timer_buffer_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fib_timer_buffer.sv
// fib_timer_buffer: elastic FIFO between the Fibonacci/Timer producers and the display consumer.
// Define FIB_TIMER_BUFFER_OVF_CNT_EN to add the saturating dropped-write counter ovf_cnt.
module fib_timer_buffer
  import fib_timer_buffer_pkg::*;
#(
  parameter int DATA_W = FTB_DATA_W,
  parameter int DEPTH  = FTB_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic [DATA_W-1:0]          data_1,
  input  logic                       data_1_en,
  input  logic                       rd_tick,
  output logic [DATA_W-1:0]          data_2,
  output logic                       data_2_valid,
  output logic                       buffer_full,
  output logic                       buffer_empty,
`ifdef FIB_TIMER_BUFFER_OVF_CNT_EN
  output logic [7:0]                 ovf_cnt,
`endif
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PTR_W = $clog2(DEPTH);
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [DATA_W-1:0] rdata;
  logic              do_rd, do_wr;
  logic [PTR_W:0]    count_n;
  // Flags are registered, so a word written this cycle is never visible to a read this cycle.
  always_comb begin
    do_rd   = rd_tick && !buffer_empty;
    do_wr   = data_1_en && (!buffer_full || do_rd);
    count_n = count + {{PTR_W{1'b0}}, do_wr} - {{PTR_W{1'b0}}, do_rd};
  end
  fib_timer_buffer_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(PTR_W)) u_mem (
    .clk  (clk),
    .we   (do_wr && !clear),
    .waddr(wr_ptr),
    .wdata(data_1),
    .raddr(rd_ptr),
    .rdata(rdata)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      data_2       <= '0;
      data_2_valid <= 1'b0;
      buffer_full  <= 1'b0;
      buffer_empty <= 1'b1;
    end else if (clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      data_2_valid <= 1'b0;
      buffer_full  <= 1'b0;
      buffer_empty <= 1'b1;
    end else begin
      wr_ptr       <= wr_ptr + PTR_W'(do_wr);
      rd_ptr       <= rd_ptr + PTR_W'(do_rd);
      count        <= count_n;
      data_2_valid <= do_rd;
      buffer_full  <= count_n == (PTR_W+1)'(DEPTH);
      buffer_empty <= count_n == '0;
      if (do_rd) data_2 <= rdata;
    end
`ifdef FIB_TIMER_BUFFER_OVF_CNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) ovf_cnt <= '0;
    else if (clear) ovf_cnt <= '0;
    else if (data_1_en && buffer_full && !do_rd && ovf_cnt != 8'hff) ovf_cnt <= ovf_cnt + 8'd1;
`endif
endmodule

// File: tb/tb_fib_timer_buffer.sv
// tb_fib_timer_buffer: randomized + directed scoreboard bench for fib_timer_buffer
module tb_fib_timer_buffer;
  localparam int DW = 16;
  localparam int DEPTH = 8;
  logic clk = 0, rst = 0, clear = 0, data_1_en = 0, rd_tick = 0;
  logic [DW-1:0] data_1 = '0, data_2;
  logic data_2_valid, buffer_full, buffer_empty;
  logic [3:0] count;
`ifdef FIB_TIMER_BUFFER_OVF_CNT_EN
  logic [7:0] ovf_cnt;
`endif
  fib_timer_buffer dut (
    .clk(clk), .rst(rst), .clear(clear), .data_1(data_1), .data_1_en(data_1_en),
    .rd_tick(rd_tick), .data_2(data_2), .data_2_valid(data_2_valid),
    .buffer_full(buffer_full), .buffer_empty(buffer_empty),
`ifdef FIB_TIMER_BUFFER_OVF_CNT_EN
    .ovf_cnt(ovf_cnt),
`endif
    .count(count)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  int mq[$];
  int exp_q[$];
  int exp_d2 = 0, exp_ovf = 0;
  bit exp_vld = 0, mon_en = 0;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step(input bit wr, input int d, input bit rd, input bit clr);
    bit rd_ok, wr_ok;
    data_1_en = wr;
    data_1 = DW'(d);
    rd_tick = rd;
    clear = clr;
    rd_ok = rd && mq.size() > 0;
    wr_ok = wr && (mq.size() < DEPTH || rd_ok);
    @(posedge clk);
    if (clr) begin
      mq.delete();
      exp_vld = 0;
      exp_ovf = 0;
    end else begin
      if (rd_ok) begin
        exp_d2 = mq.pop_front();
        exp_q.push_back(exp_d2);
      end
      exp_vld = rd_ok;
      if (wr_ok) mq.push_back(d & 16'hffff);
      if (wr && !wr_ok && exp_ovf < 255) exp_ovf++;
    end
    #2;
    data_1_en = 0;
    rd_tick = 0;
    clear = 0;
  endtask
  always @(negedge clk) if (mon_en) begin
    chk("count", int'(count), mq.size());
    chk("full", int'(buffer_full), int'(mq.size() == DEPTH));
    chk("empty", int'(buffer_empty), int'(mq.size() == 0));
    chk("valid", int'(data_2_valid), int'(exp_vld));
    chk("data_2_hold", int'(data_2), exp_d2);
`ifdef FIB_TIMER_BUFFER_OVF_CNT_EN
    chk("ovf_cnt", int'(ovf_cnt), exp_ovf);
`endif
    if (data_2_valid) begin
      if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
      else chk("pop_data", int'(data_2), exp_q.pop_front());
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  task automatic do_reset();
    #3 rst = 0;
    mon_en = 0;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(buffer_empty), 1);
    chk("rst_full", int'(buffer_full), 0);
    chk("rst_valid", int'(data_2_valid), 0);
    chk("rst_data_2", int'(data_2), 0);
    mq.delete();
    exp_q.delete();
    exp_vld = 0;
    exp_d2 = 0;
    exp_ovf = 0;
    @(posedge clk);
    #2 rst = 1;
    mon_en = 1;
  endtask
  initial begin
    int fib[8] = '{1, 1, 2, 3, 5, 8, 13, 21};
    @(posedge clk);
    do_reset();
    // mid-operation reset with count=5 and a non-zero data_2
    for (int i = 0; i < 6; i++) step(1, 100 + i, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("pre_rst_count", int'(count), 5);
    do_reset();
    // fill with Fibonacci words, then one dropped write
    for (int i = 0; i < 8; i++) step(1, fib[i], 0, 0);
    step(1, 34, 0, 0);
    step(0, 0, 0, 0);
    // drain with spaced ticks
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 0);
      repeat (3) step(0, 0, 0, 0);
    end
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("drain_hold21", int'(data_2), 21);
    // full with concurrent write and read
    for (int i = 0; i < 8; i++) step(1, $urandom_range(0, 65535), 0, 0);
    step(1, 16'h0055, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("full_rw_last", int'(data_2), 16'h0055);
    // pointer wrap with small occupancy
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    for (int i = 2; i < 20; i++) step(1, i, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("wrap_last", int'(data_2), 19);
    // clear has priority over read and write
    for (int i = 0; i < 4; i++) step(1, 200 + i, 0, 0);
    step(1, 999, 1, 1);
    step(0, 0, 0, 0);
    chk("clear_data_2", int'(data_2), 19);
    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 55, $urandom_range(0, 65535), $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 3);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fib_timer_buffer.md
Name: fib_timer_buffer

Overview:
- Elastic buffer between the Fibonacci/Timer producers and the display consumer.
- Sits directly downstream of the producers and upstream of the consumer.
- Accepts words on the producer enable and releases one word per consumer tick.
- Exports buffer_full, buffer_empty and data_2_valid, which the top-level control FSM uses for its COMM/WAIT/BUF_EMPTY transitions.

Parameters:
DATA_W, 16, width of each stored word
DEPTH, 8, number of entries; power of two, minimum 2
PTR_W, log2(DEPTH) = 3, read/write pointer width (derived, not overridden)

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous reset, active-low
clear  in  1  synchronous flush; empties the buffer
data_1  in  DATA_W  producer word
data_1_en  in  1  producer write strobe, one cycle per word
rd_tick  in  1  consumer cadence pulse, one cycle, from the slow-clock divider
data_2  out  DATA_W  word presented to the consumer
data_2_valid  out  1  data_2 is new this cycle
buffer_full  out  1  count == DEPTH
buffer_empty  out  1  count == 0
count  out  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
Reset (rst low, asynchronous):
- Pointers = 0, count = 0, data_2 = 0, data_2_valid = 0.
- buffer_empty = 1, buffer_full = 0.
- Memory contents are don't-care.

Write:
- On a clk edge with data_1_en=1 and (count<DEPTH, or a read occurs in the same cycle): mem[wr_ptr] <= data_1 and wr_ptr increments, wrapping modulo DEPTH.
- data_1_en while full with no simultaneous read: the word is dropped and nothing changes.

Read:
- On a clk edge with rd_tick=1 and count>0: data_2 <= mem[rd_ptr] and rd_ptr increments, wrapping.
- data_2_valid = 1 for exactly the following cycle. Latency is rd_tick to data_2/data_2_valid = 1 cycle.
- data_2 holds its value until the next pop.
- rd_tick while empty: no pop, data_2_valid stays 0, data_2 unchanged.

No bypass: a word written into an empty buffer is not readable in the same cycle. A rd_tick in that cycle is ignored.

Simultaneous write and read:
- Both accepted, count unchanged.
- Applies when full, because the read frees the slot.

Flags:
- buffer_full and buffer_empty are registered.
- They are consistent with count in the same cycle; no combinational path from the inputs.

clear:
- Priority over read and write in the same cycle.
- Pointers and count go to 0 and data_2_valid goes to 0. data_2 is retained.

Control FSM contract:
- BUF_EMPTY exits when buffer_empty=1 and data_2_valid=0.
- Hence data_2_valid must be 0 in the cycle after the final pop completes.

Count arithmetic:
- count' = count + (write accepted) - (read accepted).
- It never exceeds DEPTH and never underflows.

Optional Feature:
Macro FIB_TIMER_BUFFER_OVF_CNT_EN.
- Defined: adds output ovf_cnt [7:0]. It increments, saturating at 255, on each dropped write (data_1_en=1, full, no read). Cleared by rst or clear.
- Undefined: port and logic are absent; drops are silent.

Decomposition:
- Shared package: DATA_W and DEPTH defaults, and PTR_W as a derived constant.
- The same package holds the top-FSM state encodings S_IDLE..S_BUF_EMPTY, as 3-bit localparams 1..6.
- One sub-module: fib_timer_buffer_mem, a DEPTH x DATA_W register array with a synchronous write port and a combinational read address port.
- Pointer and flag logic stays in fib_timer_buffer.

Test Plan:
1. Reset: rst low mid-operation with count=5 -> immediately count=0, buffer_empty=1, buffer_full=0, data_2_valid=0, data_2=0.
2. Fill: 8 writes of 1,1,2,3,5,8,13,21, no rd_tick -> buffer_full=1 after the 8th edge. A 9th write of 34 is dropped, count stays 8, and ovf_cnt=1 when the macro is defined.
3. Drain: 8 rd_ticks spaced 4 cycles apart -> data_2 = 1,1,2,3,5,8,13,21, each with a single-cycle data_2_valid one cycle after its tick. Afterwards buffer_empty=1, and a further rd_tick gives no data_2_valid and data_2 holds 21.
4. Full with concurrent activity: at count=8, data_1_en=1 with data_1=0x0055 and rd_tick=1 in the same cycle -> count stays 8, the oldest word is popped, 0x0055 is stored and is read out 8 pops later.
5. Wrap: 20 interleaved writes (values 0..19) and reads keeping count in 1..3 -> the output order is exactly 0..19 with no loss across pointer wrap.
6. Clear priority: count=4 with clear=1, data_1_en=1 and rd_tick=1 in the same cycle -> count=0, buffer_empty=1, data_2_valid=0, data_2 unchanged.
